// File: rtl/elevator_call_dispatcher_if.sv
// elevator_call_dispatcher_if: call intake and target request signals between the dispatcher and the elevator side
interface elevator_call_dispatcher_if #(parameter int FLOOR_W = 6);
    logic               call_valid;
    logic [FLOOR_W-1:0] call_floor;
    logic               call_ready;
    logic               call_error;
    logic [FLOOR_W-1:0] elevator_floor;
    logic [FLOOR_W-1:0] requested_floor;
    logic               request_valid;
    logic [1:0]         direction;
    logic               door_open;
    logic [FLOOR_W-1:0] pending_count;
    modport master (
        input  call_valid, call_floor, elevator_floor,
        output call_ready, call_error, requested_floor, request_valid, direction, door_open, pending_count
    );
    modport slave (
        output call_valid, call_floor, elevator_floor,
        input  call_ready, call_error, requested_floor, request_valid, direction, door_open, pending_count
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: collects floor calls and issues SCAN-ordered targets with door dwell
module elevator_call_dispatcher #(
    parameter int NUM_FLOORS   = 51,
    parameter int FLOOR_W      = 6,
    parameter int DWELL_CYCLES = 8
) (
    input logic clk,
    input logic reset,
    elevator_call_dispatcher_if.master bus
);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [FLOOR_W-1:0]    LAST = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE  = NUM_FLOORS'(1);
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ARRIVE, DWELL} state_t;

    state_t                state, state_n;
    logic [NUM_FLOORS-1:0] pend_r, pend_n;
    logic [FLOOR_W-1:0]    target_r, target_n;
    logic [1:0]            dir_r, dir_n;
    logic [CW-1:0]         cnt_r, cnt_n;
    logic                  err_r, err_n;
    logic                  ready_r;
    logic [FLOOR_W-1:0]    ef, up_f, dn_f, sel_f, pc;
    logic                  up_hit, dn_hit, here_hit, sel_hit, up_near, take, absorb;

    assign ef = bus.elevator_floor;
    assign take = bus.call_valid && ready_r;

    // nearest pending floor strictly above and strictly below the cab, plus a pending bit at the cab itself
    always_comb begin
        up_hit = 1'b0;
        up_f = '0;
        dn_hit = 1'b0;
        dn_f = '0;
        here_hit = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pend_r[i] && FLOOR_W'(i) > ef) begin
                up_hit = 1'b1;
                up_f = FLOOR_W'(i);
            end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_r[i] && FLOOR_W'(i) < ef) begin
                dn_hit = 1'b1;
                dn_f = FLOOR_W'(i);
            end
            if (pend_r[i] && FLOOR_W'(i) == ef)
                here_hit = 1'b1;
        end
    end

    // SCAN choice: keep direction, reverse when nothing is ahead, nearest (ties go up) from idle
    always_comb begin
        up_near = up_hit && (!dn_hit || (up_f - ef) <= (ef - dn_f));
        sel_hit = up_hit || dn_hit || here_hit;
        sel_f = ef;
        if (dir_r == DIR_UP)
            sel_f = up_hit ? up_f : dn_hit ? dn_f : ef;
        else if (dir_r == DIR_DN)
            sel_f = dn_hit ? dn_f : up_hit ? up_f : ef;
        else
            sel_f = up_near ? up_f : dn_hit ? dn_f : ef;
    end

    // population count of the pending bitmap
    always_comb begin
        pc = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            pc = pc + FLOOR_W'(pend_r[i]);
    end

    // call intake, arrival handling and next-state decision
    always_comb begin
        state_n = state;
        pend_n = pend_r;
        target_n = target_r;
        dir_n = dir_r;
        cnt_n = cnt_r;
        err_n = 1'b0;
        absorb = 1'b0;
        if (take) begin
            if (bus.call_floor > LAST)
                err_n = 1'b1;
            else if (bus.call_floor == ef && (state == IDLE || state == DWELL))
                absorb = 1'b1;
            else
                pend_n = pend_n | (ONE << bus.call_floor);
        end
        case (state)
            IDLE: begin
                if (absorb) begin
                    state_n = DWELL;
                    cnt_n = CW'(DWELL_CYCLES);
                end else if (|pend_r)
                    state_n = ISSUE;
            end
            ISSUE: begin
                if (sel_hit) begin
                    target_n = sel_f;
                    dir_n = sel_f > ef ? DIR_UP : sel_f < ef ? DIR_DN : dir_r;
                    state_n = WAIT_ARRIVE;
                end else begin
                    dir_n = DIR_IDLE;
                    state_n = IDLE;
                end
            end
            WAIT_ARRIVE: begin
                if (ef == target_r) begin
                    pend_n = pend_n & ~(ONE << target_r);
                    cnt_n = CW'(DWELL_CYCLES);
                    state_n = DWELL;
                end else if (dir_r == DIR_UP && up_hit && up_f < target_r)
                    target_n = up_f;
                else if (dir_r == DIR_DN && dn_hit && dn_f > target_r)
                    target_n = dn_f;
            end
            default: begin
                if (absorb)
                    cnt_n = CW'(DWELL_CYCLES);
                else if (cnt_r <= CW'(1)) begin
                    cnt_n = '0;
                    state_n = (|pend_r) ? ISSUE : IDLE;
                    dir_n = (|pend_r) ? dir_r : DIR_IDLE;
                end else
                    cnt_n = cnt_r - CW'(1);
            end
        endcase
    end

    // state registers; reset clears everything immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pend_r <= '0;
            target_r <= '0;
            dir_r <= DIR_IDLE;
            cnt_r <= '0;
            err_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state <= state_n;
            pend_r <= pend_n;
            target_r <= target_n;
            dir_r <= dir_n;
            cnt_r <= cnt_n;
            err_r <= err_n;
            ready_r <= 1'b1;
        end
    end

    assign bus.call_ready = ready_r;
    assign bus.call_error = err_r;
    assign bus.requested_floor = target_r;
    assign bus.request_valid = state == WAIT_ARRIVE;
    assign bus.direction = dir_r;
    assign bus.door_open = state == DWELL;
    assign bus.pending_count = pc;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher: directed checks of call intake, SCAN targeting, dwell and reset
module tb_elevator_call_dispatcher;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    elevator_call_dispatcher_if b ();
    elevator_call_dispatcher dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic call(input int f);
        b.call_valid = 1'b1;
        b.call_floor = 6'(f);
        tick();
        b.call_valid = 1'b0;
    endtask

    initial begin
        b.call_valid = 1'b1;
        b.call_floor = 6'd30;
        b.elevator_floor = 6'd0;
        tick();
        tick();
        chk("rst_ready", 32'(b.call_ready), 0);
        chk("rst_rv", 32'(b.request_valid), 0);
        chk("rst_door", 32'(b.door_open), 0);
        chk("rst_pend", 32'(b.pending_count), 0);
        chk("rst_dir", 32'(b.direction), 0);
        chk("rst_err", 32'(b.call_error), 0);
        chk("rst_req", 32'(b.requested_floor), 0);
        b.call_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rel_ready", 32'(b.call_ready), 1);
        chk("rel_pend", 32'(b.pending_count), 0);
        // basic trip 0 -> 30
        call(30);
        chk("trip_pend", 32'(b.pending_count), 1);
        chk("trip_rv_early", 32'(b.request_valid), 0);
        tick();
        chk("trip_rv_k1", 32'(b.request_valid), 0);
        tick();
        chk("trip_rv", 32'(b.request_valid), 1);
        chk("trip_req", 32'(b.requested_floor), 30);
        chk("trip_dir", 32'(b.direction), 1);
        b.elevator_floor = 6'd30;
        tick();
        chk("arr_rv", 32'(b.request_valid), 0);
        chk("arr_door", 32'(b.door_open), 1);
        chk("arr_pend", 32'(b.pending_count), 0);
        repeat (7) tick();
        chk("dwell_last", 32'(b.door_open), 1);
        tick();
        chk("dwell_end", 32'(b.door_open), 0);
        chk("idle_dir", 32'(b.direction), 0);
        // invalid calls
        call(55);
        chk("err55", 32'(b.call_error), 1);
        chk("err55_pend", 32'(b.pending_count), 0);
        tick();
        chk("err_pulse", 32'(b.call_error), 0);
        chk("err_state", 32'(b.request_valid), 0);
        call(51);
        chk("err51", 32'(b.call_error), 1);
        chk("err51_pend", 32'(b.pending_count), 0);
        // intercept: 10 -> 40, call 25 on the way
        b.elevator_floor = 6'd10;
        call(40);
        tick();
        tick();
        chk("ic_req40", 32'(b.requested_floor), 40);
        chk("ic_dir", 32'(b.direction), 1);
        call(25);
        chk("ic_still40", 32'(b.requested_floor), 40);
        chk("ic_pend2", 32'(b.pending_count), 2);
        tick();
        chk("ic_req25", 32'(b.requested_floor), 25);
        b.elevator_floor = 6'd25;
        tick();
        chk("ic_arr_door", 32'(b.door_open), 1);
        chk("ic_arr_pend", 32'(b.pending_count), 1);
        repeat (9) tick();
        chk("ic_resume_rv", 32'(b.request_valid), 1);
        chk("ic_resume_req", 32'(b.requested_floor), 40);
        chk("ic_resume_dir", 32'(b.direction), 1);
        b.elevator_floor = 6'd40;
        tick();
        chk("ic_done_pend", 32'(b.pending_count), 0);
        repeat (8) tick();
        chk("ic_idle_dir", 32'(b.direction), 0);
        // SCAN reversal: 20 -> 44, call 5 during the trip
        b.elevator_floor = 6'd20;
        call(44);
        tick();
        tick();
        chk("scan_req44", 32'(b.requested_floor), 44);
        call(5);
        tick();
        chk("scan_keep44", 32'(b.requested_floor), 44);
        chk("scan_pend2", 32'(b.pending_count), 2);
        b.elevator_floor = 6'd44;
        tick();
        chk("scan_arr_pend", 32'(b.pending_count), 1);
        repeat (9) tick();
        chk("scan_dir_dn", 32'(b.direction), 2);
        chk("scan_req5", 32'(b.requested_floor), 5);
        chk("scan_rv", 32'(b.request_valid), 1);
        // reset mid-trip with three calls pending
        call(12);
        call(30);
        chk("mid_pend3", 32'(b.pending_count), 3);
        chk("mid_rv", 32'(b.request_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_rv", 32'(b.request_valid), 0);
        chk("mid_rst_door", 32'(b.door_open), 0);
        chk("mid_rst_pend", 32'(b.pending_count), 0);
        chk("mid_rst_dir", 32'(b.direction), 0);
        #2 reset = 1'b1;
        tick();
        chk("mid_rel_ready", 32'(b.call_ready), 1);
        // call at the cab floor while idle opens the door without setting a bit
        b.elevator_floor = 6'd7;
        call(7);
        chk("abs_door", 32'(b.door_open), 1);
        chk("abs_pend", 32'(b.pending_count), 0);
        chk("abs_rv", 32'(b.request_valid), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_call_dispatcher.md
Name: elevator_call_dispatcher

Overview:
- Request-side initiator for the elevator controller. It collects floor calls from buttons or host logic into a pending-floor bitmap and picks the next target with SCAN ordering (keep direction, reverse when nothing is left ahead).
- It drives the controller's requested_floor, watches the reported elevator_floor for arrival, and then runs a door dwell before it issues the next target.

Parameters:
- NUM_FLOORS, 51, valid floors are 0..NUM_FLOORS-1; any higher value is invalid.
- FLOOR_W, 6, width of every floor-number field.
- DWELL_CYCLES, 8, clock cycles door_open stays high after an arrival.

Ports:
- clk, input, 1, single system clock; all logic is rising-edge.
- reset, input, 1, asynchronous active-low reset: 0 resets immediately, independent of clk.
- call_valid, input, 1, a floor call is presented this cycle.
- call_floor, input, FLOOR_W, floor number of the presented call.
- call_ready, output, 1, a call is accepted on an edge where call_valid && call_ready.
- elevator_floor, input, FLOOR_W, current cab floor reported by the elevator controller.
- requested_floor, output, FLOOR_W, target floor issued to the controller.
- request_valid, output, 1, requested_floor is a live target.
- direction, output, 2, 00 idle, 01 up, 10 down.
- door_open, output, 1, high during dwell.
- pending_count, output, FLOOR_W, number of set bits in the pending bitmap.
- call_error, output, 1, one-cycle pulse when an invalid call is presented.

Behaviour:
- Reset values (reset=0), applied asynchronously: every output 0, pending bitmap cleared, dwell counter 0, state IDLE.
- call_ready goes to 1 on the first clk edge after reset deasserts and stays 1.
- Call acceptance on an edge:
  - call_floor >= NUM_FLOORS: call_error=1 for exactly one cycle; the bitmap is not touched.
  - call_floor equals elevator_floor while in IDLE or DWELL: the call is absorbed and no bit is set. In IDLE it causes an immediate transition to DWELL. In DWELL it reloads the dwell counter.
  - Otherwise: set the bit for that floor. A duplicate call changes nothing.
  - A new bit becomes visible to target selection on the following cycle.
- Target selection (combinational over the registered bitmap):
  - Going up: lowest pending floor above elevator_floor.
  - Going down: highest pending floor below elevator_floor.
  - From idle: nearest pending floor; on an equal-distance tie, pick up.
  - If nothing is pending in the current direction, reverse. If nothing is pending at all, go idle.
- States:
  - IDLE: direction=00, request_valid=0. If any bit is pending, go to ISSUE.
  - ISSUE (1 cycle): latch target and direction, go to WAIT_ARRIVE.
  - WAIT_ARRIVE: request_valid=1, requested_floor=target.
    - Each cycle, re-run selection in the current direction so a newly accepted call between the cab and the target replaces the target (intercept).
    - The old target's bit stays set and is served later.
    - On elevator_floor == target: clear that bit, request_valid=0, door_open=1, load the dwell counter with DWELL_CYCLES, go to DWELL. All of this happens on the same edge.
  - DWELL: counter decrements each cycle.
    - At 0: door_open=0.
    - If any bit is still pending, go to ISSUE and keep direction (reversal is resolved by selection). Otherwise go to IDLE.
- Latency: a call accepted at edge k while in IDLE gives request_valid=1 after edge k+2.
- Simultaneous events:
  - An arrival clear and a new call for the same floor on the same edge: the call is absorbed and the bit ends up clear.
  - An arrival and a call for another floor on the same edge: both take effect.
- pending_count updates on the same edge the bitmap changes.
- An elevator_floor value that is invalid or outside the range between the cab and the target is ignored for arrival; only equality matters.
- Reset mid-operation: an in-flight request is dropped immediately (request_valid=0 asynchronously) and all pending calls are lost.

Test Plan:
- Reset: hold reset=0 with call_valid=1 -> all outputs 0, no call accepted. Release -> call_ready=1 after the first edge, pending_count=0.
- Basic trip: elevator_floor=0, call 30 at edge k -> after edge k+2: requested_floor=30, request_valid=1, direction=01, pending_count=1. Drive elevator_floor=30 -> next edge: request_valid=0, door_open=1 for 8 cycles, pending_count=0. Then direction=00.
- Invalid call: call_floor=55 -> call_error high exactly one cycle, pending_count unchanged, state unchanged.
- Intercept: cab at 10, heading to 40, call 25 -> requested_floor becomes 25. After arrival at 25 and dwell -> requested_floor=40 with direction still 01.
- SCAN reversal: cab at 20 going up to 44, call 5 during the trip -> 44 is served first. After dwell -> direction=10, requested_floor=5.
- Reset mid-trip: reset=0 while request_valid=1 with 3 calls pending -> request_valid, door_open and pending_count are 0 immediately, without waiting for a clock edge.
